// File: rtl/vga_scanout_pkg.sv
// vga_scanout_pkg
//   Types and constants shared between the plotter and the VGA scanout.
//   pixel_t      : packed RGBA pixel, 8 bits per channel (r in the MSBs).
//   pos_flags_t  : per-position timing flags carried down the read pipeline.
//   FB_*         : framebuffer geometry and address width.
//   VGA_*        : 640x480@60 timing, used as parameter defaults.
package vga_scanout_pkg;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_ADDR_W = 19;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_READ_LATENCY = 1;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] a;
    } pixel_t;

    typedef struct packed {
        logic active;  // inside the visible region
        logic hs;      // raw hsync, active-high
        logic vs;      // raw vsync, active-high
        logic first;   // position (0,0)
    } pos_flags_t;

    // Total clocks (or lines) of one timing axis.
    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_scanout_timing.sv
// vga_timing
//   Free-running horizontal/vertical counters and the position flags derived
//   from them (active region, raw hsync/vsync, first pixel).
//   Ports:
//     clock  in  pixel clock
//     reset  in  synchronous, active-high; counters return to (0,0)
//     flags  out pos_flags_t for the current (h_count, v_count)
module vga_timing
    import vga_scanout_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic       clock,
    input  logic       reset,
    output pos_flags_t flags
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_W-1:0] h_count;
    logic [V_W-1:0] v_count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
        end else begin
            h_count <= h_count + 1'b1;
        end
    end

    // NOTE: the whole struct gets a default before field assignments so no
    // bit can hold its old value and infer a latch.
    always_comb begin
        flags        = '0;
        flags.active = (h_count < H_ACT) && (v_count < V_ACT);
        flags.hs     = (h_count >= HS_START) && (h_count < HS_END);
        flags.vs     = (v_count >= VS_START) && (v_count < VS_END);
        flags.first  = (h_count == '0) && (v_count == '0);
    end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout
//   Streams the framebuffer out as VGA: walks the raster, issues one
//   framebuffer read per visible position, and re-aligns the timing flags with
//   the returned data so pixel/de/hsync/vsync/frame_start leave together,
//   READ_LATENCY+1 clocks after the position was generated.
//   Ports:
//     clock        in  pixel clock
//     reset        in  synchronous, active-high
//     rd_address   out framebuffer read address, row-major
//     rd_en        out read strobe, visible positions only
//     rd_data      in  framebuffer data, READ_LATENCY clocks after rd_address
//     pixel        out output pixel, zero outside the visible region
//     de           out data enable
//     hsync, vsync out sync outputs, polarity set by SYNC_ACTIVE_LOW
//     frame_start  out one-clock pulse with output pixel (0,0)
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int H_ACTIVE        = VGA_H_ACTIVE,
    parameter int H_FP            = VGA_H_FP,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BP            = VGA_H_BP,
    parameter int V_ACTIVE        = VGA_V_ACTIVE,
    parameter int V_FP            = VGA_V_FP,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_BP            = VGA_V_BP,
    parameter int READ_LATENCY    = VGA_READ_LATENCY,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [FB_ADDR_W-1:0] rd_address,
    output logic                 rd_en,
    input  pixel_t               rd_data,
    output pixel_t               pixel,
    output logic                 de,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 frame_start
);

    localparam logic [FB_ADDR_W-1:0] ADDR_LAST = FB_ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    pos_flags_t pos;
    pos_flags_t dly [READ_LATENCY];
    pos_flags_t tail;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clock (clock),
        .reset (reset),
        .flags (pos)
    );

    // The counters already sit at (0,0) while reset is held; gating keeps the
    // bus quiet until the first clock after release.
    assign rd_en = pos.active & ~reset;

    // Running address instead of v*H_ACTIVE+h: visible positions are visited
    // in row-major order, so a +1 per read is exact. It holds through blanking
    // and wraps after the last visible pixel of the frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_address <= '0;
        end else if (pos.active) begin
            rd_address <= (rd_address == ADDR_LAST) ? '0 : rd_address + 1'b1;
        end
    end

    // Flags travel alongside the read so they meet rd_data in the same cycle.
    // NOTE: the delay line is reset (unlike a data RAM) because its contents
    // drive de/frame_start directly; stale entries would leak after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                dly[i] <= '0;
            end
        end else begin
            dly[0] <= pos;
            for (int i = 1; i < READ_LATENCY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign tail = dly[READ_LATENCY-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            pixel       <= '0;
            de          <= 1'b0;
            hsync       <= SYNC_ACTIVE_LOW;
            vsync       <= SYNC_ACTIVE_LOW;
            frame_start <= 1'b0;
        end else begin
            pixel       <= tail.active ? rd_data : '0;
            de          <= tail.active;
            hsync       <= tail.hs ^ SYNC_ACTIVE_LOW;
            vsync       <= tail.vs ^ SYNC_ACTIVE_LOW;
            frame_start <= tail.first;
        end
    end

endmodule
